// File: rtl/req_encoder_16x4_if.sv
// Request/output bundle for req_encoder_16x4: capture inputs plus the valid/ready code stream.
// The master modport is the encoder's view; slave is the event-source/consumer side.
interface req_encoder_16x4_if;
  logic        en;
  logic [15:0] req;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  code;
  logic [15:0] pending;
  logic        ovf;

  modport master (
    input  en,
    input  req,
    input  out_ready,
    output out_valid,
    output code,
    output pending,
    output ovf
  );

  modport slave (
    output en,
    output req,
    output out_ready,
    input  out_valid,
    input  code,
    input  pending,
    input  ovf
  );
endinterface

// File: rtl/req_encoder_16x4.sv
// Sequential 16-to-4 request encoder: latches requests into a pending set and issues one index
// per valid/ready handshake. Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection.
module req_encoder_16x4 (
  input  logic                      clk,
  input  logic                      rst,
  req_encoder_16x4_if.master        bus
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  code_q, code_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  last_q, last_d;

  logic [15:0] cap;
  logic [15:0] clr;
  logic [3:0]  sel_idx;
  logic        sel_found;

  assign cap = bus.req & {16{bus.en}};

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  // Walk downward from the farthest offset so the nearest set bit after last_q wins.
  always_comb begin
    sel_idx   = 4'd0;
    sel_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[last_q + 4'(i) + 4'd1]) begin
        sel_idx   = last_q + 4'(i) + 4'd1;
        sel_found = 1'b1;
      end
    end
  end
`else
  // Ascending scan; later hits overwrite, so the highest set index wins.
  always_comb begin
    sel_idx   = 4'd0;
    sel_found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pending_q[i]) begin
        sel_idx   = 4'(i);
        sel_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    code_d      = code_q;
    last_d      = last_q;
    clr         = 16'h0000;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          clr         = 16'h0001 << sel_idx;
          code_d      = sel_idx;
          out_valid_d = 1'b1;
          last_d      = sel_idx;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
    // A same-cycle set beats the issue clear.
    pending_d = (pending_q & ~clr) | cap;
    ovf_d     = |(cap & pending_q & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= 16'h0000;
      out_valid_q <= 1'b0;
      code_q      <= 4'd0;
      ovf_q       <= 1'b0;
      last_q      <= 4'd15;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.code      = code_q;
  assign bus.pending   = pending_q;
  assign bus.ovf       = ovf_q;

endmodule
